// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset/step defaults, buffer depth and a word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_STEP_DEFAULT  = 4;
    localparam int          FIFO_DEPTH       = 2;
    localparam int          COUNT_W          = $clog2(FIFO_DEPTH + 1);

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, instruction} buffer; entry 0 is always the head so the
// head output comes straight from a register.
module fetch_buffer
    import fetch_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic               i_flush,
    input  logic [63:0]        i_din,
    output logic [63:0]        o_head,
    output logic [COUNT_W-1:0] o_count
);

    logic [63:0]        r_ent0;
    logic [63:0]        r_ent1;
    logic [COUNT_W-1:0] r_count;

    // Shift-style storage update; flush only clears occupancy.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ent0  <= 64'd0;
            r_ent1  <= 64'd0;
            r_count <= '0;
        end else if (i_flush) begin
            r_count <= '0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == COUNT_W'(0)) begin
                        r_ent0 <= i_din;
                    end else begin
                        r_ent1 <= i_din;
                    end
                    r_count <= r_count + COUNT_W'(1);
                end
                2'b01: begin
                    r_ent0  <= r_ent1;
                    r_count <= r_count - COUNT_W'(1);
                end
                2'b11: begin
                    if (r_count == COUNT_W'(1)) begin
                        r_ent0 <= i_din;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= i_din;
                    end
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign o_head  = r_ent0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single outstanding memory request, two-entry
// prefetch buffer to decode, branch redirect with in-flight response drop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] in_mem_addr,
    output logic        in_mem_en,
    input  logic [31:0] in_mem,
    input  logic        in_mem_valid,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_t       r_state;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_mem_addr;
    logic               r_mem_en;

    logic [COUNT_W-1:0] w_count;
    logic [63:0]        w_head;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    logic [31:0]        w_target;
    logic [31:0]        w_next_pc;

    assign w_accept  = r_mem_en & in_mem_valid;
    assign w_pop     = instr_valid & decode_ready & ~branch_taken;
    assign w_push    = w_accept & (r_state == FETCH) & ~branch_taken;
    assign w_target  = align_word(branch_target);
    assign w_next_pc = r_fetch_pc + STEP;

    fetch_buffer u_buffer (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (branch_taken),
        .i_din   ({r_fetch_pc, in_mem}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Request/redirect state machine; redirect overrides every other transition.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_en   <= 1'b0;
        end else if (branch_taken) begin
            r_fetch_pc <= w_target;
            if (r_mem_en && !in_mem_valid) begin
                // The old request must still complete before retargeting.
                r_state <= DROP;
            end else begin
                r_state    <= FETCH;
                r_mem_en   <= 1'b1;
                r_mem_addr <= w_target;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_accept) begin
                        r_fetch_pc <= w_next_pc;
                        if ((w_count == COUNT_W'(FIFO_DEPTH - 1)) && !w_pop) begin
                            r_state  <= FULL;
                            r_mem_en <= 1'b0;
                        end else begin
                            r_mem_en   <= 1'b1;
                            r_mem_addr <= w_next_pc;
                        end
                    end else begin
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state    <= FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end else begin
                        r_mem_en <= 1'b0;
                    end
                end
                DROP: begin
                    if (in_mem_valid) begin
                        r_state    <= FETCH;
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_fetch_pc;
                    end else begin
                        r_mem_en <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= FETCH;
                    r_mem_en <= 1'b0;
                end
            endcase
        end
    end

    assign in_mem_addr = r_mem_addr;
    assign in_mem_en   = r_mem_en;
    assign instr_valid = (w_count != COUNT_W'(0));
    assign instr_pc    = w_head[63:32];
    assign instruction = w_head[31:0];

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter PC_STEP, default 4: byte increment between sequential fetches.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
REQ-005 in_mem_addr  output  32  instruction memory byte address.
REQ-006 in_mem_en  output  1  fetch request; held high until accepted.
REQ-007 in_mem  input  32  instruction word from memory; valid only with in_mem_valid.
REQ-008 in_mem_valid  input  1  memory ack; request accepted on a cycle with in_mem_en=1 and in_mem_valid=1.
REQ-009 instruction  output  32  head instruction presented to decode.
REQ-010 instr_pc  output  32  address of head instruction.
REQ-011 instr_valid  output  1  head entry valid.
REQ-012 decode_ready  input  1  decode consumes head on a cycle with instr_valid=1 and decode_ready=1 (pop).
REQ-013 branch_taken  input  1  redirect request from execute, single-cycle pulse.
REQ-014 branch_target  input  32  redirect address; bits [1:0] SHALL be ignored (forced 0).

Function
REQ-015 The block SHALL contain fetch_pc (next address to request), a 2-entry FIFO of {pc, instruction}, and a state register with states FETCH, FULL, DROP.
REQ-016 At most one memory request SHALL be outstanding; in_mem_addr SHALL remain stable while in_mem_en=1 and in_mem_valid=0.
REQ-017 FETCH: in_mem_en=1, in_mem_addr=fetch_pc; on accept, push {fetch_pc, in_mem} and advance fetch_pc by PC_STEP (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000).
REQ-018 FETCH -> FULL when an accept brings the FIFO count to 2 with no pop that cycle; FULL: in_mem_en=0.
REQ-019 FULL -> FETCH on any pop; the request SHALL be raised the cycle after the pop.
REQ-020 A request SHALL be raised only when FIFO count < 2, so every accept has a free slot; push and pop in the same cycle SHALL leave count unchanged.
REQ-021 Fetch latency: a word accepted in cycle N SHALL appear on instruction/instr_pc with instr_valid=1 in cycle N+1 when the FIFO was empty.
REQ-022 instr_valid SHALL equal (count != 0); instruction/instr_pc SHALL hold the head entry and remain stable while instr_valid=1 and decode_ready=0.
REQ-023 Redirect (branch_taken=1) SHALL have priority over push, pop and state transitions: FIFO flushed (count=0, instr_valid=0 next cycle), fetch_pc <= {branch_target[31:2], 2'b00}.
REQ-024 Redirect with no request pending, or coinciding with an accept: that response SHALL be discarded; next state FETCH, request to target raised the next cycle.
REQ-025 Redirect while in_mem_en=1 and in_mem_valid=0: enter DROP; DROP keeps in_mem_en=1 and the old address until in_mem_valid=1, discards that word, then enters FETCH with target address.
REQ-026 A further redirect in DROP SHALL update fetch_pc to the newest target and remain in DROP.
REQ-027 A pop coinciding with a redirect SHALL be a no-op (entry flushed regardless).

Reset
REQ-028 When reset=0 at a clock edge: fetch_pc=RESET_PC, FIFO count=0, state=FETCH, in_mem_en=0, in_mem_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
REQ-029 in_mem_en SHALL remain 0 throughout reset and rise in the first cycle after reset releases.
REQ-030 Reset asserted mid-request SHALL abandon the outstanding request; no response after release SHALL be pushed unless requested after release.

Structure
REQ-031 Shared package fetch_pkg SHALL hold the state enum (FETCH, FULL, DROP), RESET_PC default, PC_STEP default and FIFO depth constant 2.
REQ-032 The FIFO SHALL be a sub-module fetch_buffer (2 entries, 64-bit {pc, instr}, push/pop/flush, count output).

Verification
REQ-033 Reset release, memory acks every cycle, decode_ready=1 -> in_mem_addr 0x0, 0x4, 0x8 on consecutive cycles; instr_pc 0x0 first seen with instr_valid=1 one cycle after first accept.
REQ-034 decode_ready=0, memory acks immediately -> two words buffered (pc 0x0, 0x4), in_mem_en=0; raise decode_ready -> head 0x0 pops, request for 0x8 next cycle.
REQ-035 Request to 0x8 pending (in_mem_valid=0), branch_taken with target 0x103 -> DROP; response for 0x8 discarded; next request address 0x100; instr_pc 0x100 first valid output.
REQ-036 branch_taken same cycle as accept of 0x4, target 0x40 -> word 0x4 never presented; instr_valid=0 next cycle; next in_mem_addr 0x40.
REQ-037 fetch_pc forced to 0xFFFF_FFFC via redirect -> following request address 0x0000_0000.
REQ-038 reset=0 asserted while request pending and FIFO holding 2 entries -> next cycle instr_valid=0, in_mem_en=0, in_mem_addr=RESET_PC.
